// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-file writeback unit: load
// funct3 codes, the buffered result entry, and load byte/half extraction.
package wb_pkg;

   localparam int WB_XLEN = 32;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   typedef struct packed {
      logic [4:0]         index;
      logic [WB_XLEN-1:0] data;
   } wb_entry_t;

   // Returns {ok, data}; ok=0 for an unknown funct3 or a misaligned offset.
   function automatic logic [WB_XLEN:0] load_extract(input logic [WB_XLEN-1:0] raw,
                                                      input logic [2:0]         funct3,
                                                      input logic [1:0]         offset);
      logic [7:0]         b;
      logic [15:0]        h;
      logic               ok;
      logic [WB_XLEN-1:0] data;
      b    = raw[{offset, 3'b000} +: 8];
      h    = raw[{offset[1], 4'b0000} +: 16];
      ok   = 1'b0;
      data = '0;
      case (funct3)
         LB:  begin ok = 1'b1;         data = {{(WB_XLEN-8){b[7]}}, b};   end
         LH:  begin ok = !offset[0];   data = {{(WB_XLEN-16){h[15]}}, h}; end
         LW:  begin ok = (offset == 2'd0); data = raw;                    end
         LBU: begin ok = 1'b1;         data = {{(WB_XLEN-8){1'b0}}, b};   end
         LHU: begin ok = !offset[0];   data = {{(WB_XLEN-16){1'b0}}, h};  end
         default: begin ok = 1'b0;     data = '0;                         end
      endcase
      if (!ok) data = '0;
      return {ok, data};
   endfunction

endpackage

// File: rtl/regfile_writeback_unit_if.sv
// Writeback unit bus: ALU result, LSU load handshake, decode issue,
// pending scoreboard and the register file rd write port.
// LSU channel: a beat transfers on the rising edge where lsu_wb_valid and
// lsu_wb_ready are both high; valid must not depend on ready. ALU results
// have no ready and are always taken in the cycle they are presented.
interface regfile_writeback_unit_if import wb_pkg::*; #(parameter int XLEN = WB_XLEN);

   logic            alu_wb_valid;
   logic [4:0]      alu_wb_index;
   logic [XLEN-1:0] alu_wb_data;
   logic            lsu_wb_valid;
   logic            lsu_wb_ready;
   logic [4:0]      lsu_wb_index;
   logic [XLEN-1:0] lsu_wb_raw;
   logic [2:0]      lsu_wb_funct3;
   logic [1:0]      lsu_wb_byte_offset;
   logic            lsu_wb_error;
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic [31:0]     pending_mask;
   logic [4:0]      rd_write_index;
   logic [XLEN-1:0] rd_write_data;
   logic            rd_write_enable;

   // Writeback unit side.
   modport master (
      input  alu_wb_valid, alu_wb_index, alu_wb_data,
      input  lsu_wb_valid, lsu_wb_index, lsu_wb_raw, lsu_wb_funct3, lsu_wb_byte_offset,
      input  issue_valid, issue_rd,
      output lsu_wb_ready, lsu_wb_error, pending_mask,
      output rd_write_index, rd_write_data, rd_write_enable
   );

   // Environment side (ALU, LSU, decode, register file).
   modport slave (
      output alu_wb_valid, alu_wb_index, alu_wb_data,
      output lsu_wb_valid, lsu_wb_index, lsu_wb_raw, lsu_wb_funct3, lsu_wb_byte_offset,
      output issue_valid, issue_rd,
      input  lsu_wb_ready, lsu_wb_error, pending_mask,
      input  rd_write_index, rd_write_data, rd_write_enable
   );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries; pointers wrap modulo DEPTH
// (power of two). Push when full and pop when empty are ignored.
module wb_fifo import wb_pkg::*; #(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  wb_entry_t              push_data,
   input  logic                   pop,
   output wb_entry_t              pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic             push_ok, pop_ok;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;

   // Next pointers, occupancy and storage contents.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; reset discards all entries.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset; occupancy gates what is visible.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/regfile_writeback_unit.sv
// Register file rd write initiator: ALU results win the single write slot,
// extracted LSU loads queue in a FIFO, x0 writes are swallowed, and a
// pending scoreboard tracks outstanding producers for decode.
module regfile_writeback_unit import wb_pkg::*; #(
   parameter int XLEN       = WB_XLEN,
   parameter int FIFO_DEPTH = 2
) (
   input logic                     clk,
   input logic                     rst_n,
   regfile_writeback_unit_if.master wb
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   wb_entry_t        push_entry, head_entry;
   logic             push, pop, full, empty;
   logic [CNT_W-1:0] count;
   logic [WB_XLEN:0] ext;
   logic             load_ok, lsu_ready, lsu_fire;

   logic             sel;
   logic [4:0]       sel_idx;
   logic [XLEN-1:0]  sel_data;
   logic [31:0]      clr_mask, set_mask;

   logic             rd_we_q, rd_we_d;
   logic [4:0]       rd_idx_q, rd_idx_d;
   logic [XLEN-1:0]  rd_data_q, rd_data_d;
   logic             err_q, err_d;
   logic [31:0]      pending_q, pending_d;

   // Ready comes only from the registered occupancy: no credit for a pop.
   assign lsu_ready = (count != CNT_W'(FIFO_DEPTH));
   assign lsu_fire  = wb.lsu_wb_valid && lsu_ready;
   assign ext       = load_extract(wb.lsu_wb_raw, wb.lsu_wb_funct3, wb.lsu_wb_byte_offset);
   assign load_ok   = ext[WB_XLEN];
   assign push      = lsu_fire && load_ok && !full;
   assign push_entry = '{index: wb.lsu_wb_index, data: ext[WB_XLEN-1:0]};

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head_entry),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   // Write-slot arbitration, output register inputs and scoreboard update.
   always_comb begin
      sel      = 1'b0;
      sel_idx  = '0;
      sel_data = '0;
      pop      = 1'b0;
      if (wb.alu_wb_valid) begin
         sel      = 1'b1;
         sel_idx  = wb.alu_wb_index;
         sel_data = wb.alu_wb_data;
      end else if (!empty) begin
         pop      = 1'b1;
         sel      = 1'b1;
         sel_idx  = head_entry.index;
         sel_data = head_entry.data;
      end
      rd_we_d   = sel && (sel_idx != 5'd0);
      rd_idx_d  = sel_idx;
      rd_data_d = sel_data;
      err_d     = lsu_fire && !load_ok;
      clr_mask  = sel ? (32'd1 << sel_idx) : 32'd0;
      set_mask  = wb.issue_valid ? (32'd1 << wb.issue_rd) : 32'd0;
      // Set is applied after clear so a same-edge issue keeps the bit.
      pending_d    = (pending_q & ~clr_mask) | set_mask;
      pending_d[0] = 1'b0;
   end

   // Output port, error pulse and scoreboard registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_we_q   <= 1'b0;
         rd_idx_q  <= '0;
         rd_data_q <= '0;
         err_q     <= 1'b0;
         pending_q <= '0;
      end else begin
         rd_we_q   <= rd_we_d;
         rd_idx_q  <= rd_idx_d;
         rd_data_q <= rd_data_d;
         err_q     <= err_d;
         pending_q <= pending_d;
      end
   end

   assign wb.lsu_wb_ready    = lsu_ready;
   assign wb.lsu_wb_error    = err_q;
   assign wb.pending_mask    = pending_q;
   assign wb.rd_write_enable = rd_we_q;
   assign wb.rd_write_index  = rd_idx_q;
   assign wb.rd_write_data   = rd_data_q;

endmodule
